// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and a packed-field extractor shared by the register file blocks.
package regfile_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int VEC_MAX        = 256;
   localparam int FIELD_MAX      = 64;
   // Field idx of a vector of width-bit fields (field 0 in the LSBs), zero-extended.
   function automatic logic [FIELD_MAX-1:0] get_field(input logic [VEC_MAX-1:0] vec, input int idx, input int width);
      logic [VEC_MAX-1:0]   sh;
      logic [FIELD_MAX-1:0] mask;
      sh   = vec >> (idx * width);
      mask = (width >= FIELD_MAX) ? '1 : ((FIELD_MAX'(1) << width) - FIELD_MAX'(1));
      return sh[FIELD_MAX-1:0] & mask;
   endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits; a set beats a same-cycle write clear.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_WR     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         set_en_i,
   input  logic [ADDR_WIDTH-1:0]        set_addr_i,
   input  logic [NUM_WR-1:0]            wr_en_i,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
   output logic [2**ADDR_WIDTH-1:0]     busy_o
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   logic [DEPTH-1:0]   busy_q, busy_d;
   logic [VEC_MAX-1:0] wr_addr_w;
   assign wr_addr_w = VEC_MAX'(wr_addr_i);
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NUM_WR; j++)
         if (wr_en_i[j]) busy_d[ADDR_WIDTH'(get_field(wr_addr_w, j, ADDR_WIDTH))] = 1'b0;
      if (set_en_i) busy_d[set_addr_i] = 1'b1;
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) busy_q <= '0;
      else busy_q <= busy_d;
   assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multiport register file with zero-latency reads, collision flag and write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and cleared busy) to matching reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic                         sb_set_en,
   input  logic [ADDR_WIDTH-1:0]        sb_set_addr,
   output logic                         wr_collide
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic                  collide_q, collide_d;
   logic [VEC_MAX-1:0]    wa_w, wd_w, ra_w;
   logic [ADDR_WIDTH-1:0] wa [NUM_WR];
   logic [DATA_WIDTH-1:0] wd [NUM_WR];
   logic [ADDR_WIDTH-1:0] ra [NUM_RD];
   logic [ADDR_WIDTH-1:0] wa1;
   assign wa_w = VEC_MAX'(wr_addr);
   assign wd_w = VEC_MAX'(wr_data);
   assign ra_w = VEC_MAX'(rd_addr);
   // Field 1 reads as zero when only one write port exists, so no collision is possible then.
   assign wa1  = ADDR_WIDTH'(get_field(wa_w, 1, ADDR_WIDTH));
   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         wa[j] = ADDR_WIDTH'(get_field(wa_w, j, ADDR_WIDTH));
         wd[j] = DATA_WIDTH'(get_field(wd_w, j, DATA_WIDTH));
      end
      for (int i = 0; i < NUM_RD; i++) ra[i] = ADDR_WIDTH'(get_field(ra_w, i, ADDR_WIDTH));
   end
   always_comb begin
      mem_d = mem_q;
      for (int j = 0; j < NUM_WR; j++)
         if (wr_en[j] && wa[j] != '0) mem_d[wa[j]] = wd[j];
      collide_d = NUM_WR > 1 && (&wr_en) && wa[0] == wa1 && wa[0] != '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem_q     <= '{default: '0};
         collide_q <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         collide_q <= collide_d;
      end
   regfile_scoreboard #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .NUM_WR    (NUM_WR)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en_i  (sb_set_en),
      .set_addr_i(sb_set_addr),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .busy_o    (busy)
   );
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra[i]];
         rd_busy[i] = busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
         for (int j = 0; j < NUM_WR; j++)
            if (rst_n && wr_en[j] && wa[j] == ra[i] && ra[i] != '0) begin
               rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wd[j];
               rd_busy[i] = sb_set_en && sb_set_addr == ra[i];
            end
`endif
      end
   end
   assign wr_collide = collide_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench with an array model checked every cycle plus literal expectations.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]   wr_en;
   logic [9:0]   wr_addr;
   logic [63:0]  wr_data;
   logic [9:0]   rd_addr;
   logic [63:0]  rd_data;
   logic [1:0]   rd_busy;
   logic         sb_set_en;
   logic [4:0]   sb_set_addr;
   logic         wr_collide;

   logic [1:0]   p_wr_en;
   logic [11:0]  p_wr_addr;
   logic [127:0] p_wr_data;
   logic [23:0]  p_rd_addr;
   logic [255:0] p_rd_data;
   logic [3:0]   p_rd_busy;
   logic         p_sb_set_en;
   logic [5:0]   p_sb_set_addr;
   logic         p_wr_collide;

   int checks = 0;
   int errors = 0;

   regfile_mp dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .wr_collide(wr_collide)
   );

   regfile_mp #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .NUM_RD(4), .NUM_WR(2)) dut_p (
      .clk(clk), .rst_n(rst_n), .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
      .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
      .sb_set_en(p_sb_set_en), .sb_set_addr(p_sb_set_addr), .wr_collide(p_wr_collide)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: array contents, pending bits and the collision flag of the default instance.
   logic [31:0] m_mem [32];
   logic        m_busy [32];
   logic        m_collide;

   function automatic logic [4:0] wa(input int j);
      return wr_addr[j*5 +: 5];
   endfunction
   function automatic logic [31:0] wd(input int j);
      return wr_data[j*32 +: 32];
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int k = 0; k < 32; k++) begin
            m_mem[k]  <= 32'h0;
            m_busy[k] <= 1'b0;
         end
         m_collide <= 1'b0;
      end else begin
         for (int j = 0; j < 2; j++) if (wr_en[j] && wa(j) != 0) m_mem[wa(j)] <= wd(j);
         for (int j = 0; j < 2; j++) if (wr_en[j]) m_busy[wa(j)] <= 1'b0;
         if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] <= 1'b1;
         m_collide <= wr_en == 2'b11 && wa(0) == wa(1) && wa(0) != 0;
      end

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      v = (rst_n && a != 0) ? m_mem[a] : 32'h0;
      if (BYP && rst_n && a != 0)
         for (int j = 0; j < 2; j++) if (wr_en[j] && wa(j) == a) v = wd(j);
      return v;
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      logic b;
      b = (rst_n && a != 0) ? m_busy[a] : 1'b0;
      if (BYP && rst_n && a != 0)
         for (int j = 0; j < 2; j++) if (wr_en[j] && wa(j) == a) b = sb_set_en && sb_set_addr == a;
      return b;
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("model rd_data[%0d]", i), 64'(rd_data[i*32 +: 32]), 64'(exp_rd(rd_addr[i*5 +: 5])));
         chk($sformatf("model rd_busy[%0d]", i), 64'(rd_busy[i]), 64'(exp_busy(rd_addr[i*5 +: 5])));
      end
      chk("model wr_collide", 64'(wr_collide), 64'(rst_n && m_collide));
   end

   task automatic drive(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] r0,
                        input logic [4:0] r1, input logic se, input logic [4:0] sa);
      @(posedge clk);
      #1;
      wr_en = we; wr_addr = {a1, a0}; wr_data = {d1, d0};
      rd_addr = {r1, r0}; sb_set_en = se; sb_set_addr = sa;
      @(negedge clk);
   endtask

   task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, r0, r1, 1'b0, 5'd0);
   endtask

   initial begin
      wr_en = '0; wr_addr = {5'd0, 5'd0}; wr_data = '0; rd_addr = {5'd1, 5'd5};
      sb_set_en = 1'b0; sb_set_addr = '0;
      p_wr_en = '0; p_wr_addr = '0; p_wr_data = '0; p_rd_addr = {4{6'd63}};
      p_sb_set_en = 1'b0; p_sb_set_addr = '0;
      repeat (2) @(negedge clk);
      chk("reset rd_data", rd_data, 64'h0);
      chk("reset rd_busy", 64'(rd_busy), 64'h0);
      chk("reset wr_collide", 64'(wr_collide), 64'h0);
      chk("reset param rd_data", p_rd_data[63:0], 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      drive(2'b01, 5'd5, 32'h1111_1111, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 5'd5);
      chk("r5 before reset", 64'(rd_data[31:0]), 64'h1111_1111);
      idle(5'd5, 5'd5);
      chk("r5 busy before reset", 64'(rd_busy[0]), 64'h1);

      // Reset asserted while a write of DEADBEEF to r5 is pending.
      @(posedge clk);
      #1;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEAD_BEEF};
      sb_set_en = 1'b1; sb_set_addr = 5'd5;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("mid-write reset rd_data", 64'(rd_data[31:0]), 64'h0);
      chk("mid-write reset rd_busy", 64'(rd_busy), 64'h0);
      chk("mid-write reset wr_collide", 64'(wr_collide), 64'h0);
      idle(5'd5, 5'd5);
      rst_n = 1'b1;
      idle(5'd5, 5'd5);
      chk("r5 after reset", 64'(rd_data[31:0]), 64'h0);
      chk("r5 busy after reset", 64'(rd_busy[0]), 64'h0);

      drive(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
      idle(5'd0, 5'd0);
      chk("x0 rd_data", rd_data, 64'h0);
      chk("x0 rd_busy", 64'(rd_busy), 64'h0);

      drive(2'b11, 5'd7, 32'hAAAA_0000, 5'd7, 32'h5555_0000, 5'd7, 5'd0, 1'b0, 5'd0);
      idle(5'd7, 5'd7);
      chk("collision winner", 64'(rd_data[63:32]), 64'h5555_0000);
      chk("collision pulse", 64'(wr_collide), 64'h1);
      idle(5'd7, 5'd7);
      chk("collision pulse end", 64'(wr_collide), 64'h0);

      drive(2'b11, 5'd11, 32'hB0B0_B0B0, 5'd12, 32'hC0C0_C0C0, 5'd11, 5'd12, 1'b0, 5'd0);
      idle(5'd11, 5'd12);
      chk("dual write port0", 64'(rd_data[31:0]), 64'hB0B0_B0B0);
      chk("dual write port1", 64'(rd_data[63:32]), 64'hC0C0_C0C0);
      chk("dual write no collide", 64'(wr_collide), 64'h0);
      drive(2'b11, 5'd0, 32'h1, 5'd0, 32'h2, 5'd0, 5'd0, 1'b0, 5'd0);
      idle(5'd0, 5'd0);
      chk("x0 collide ignored", 64'(wr_collide), 64'h0);

      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3);
      drive(2'b10, 5'd0, 32'h0, 5'd3, 32'h3, 5'd3, 5'd3, 1'b1, 5'd3);
      idle(5'd3, 5'd4);
      chk("set beats clear", 64'(rd_busy[0]), 64'h1);
      drive(2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 5'd3, 5'd4, 1'b1, 5'd4);
      idle(5'd3, 5'd4);
      chk("plain write clears r3", 64'(rd_busy[0]), 64'h0);
      chk("set r4 alongside clear", 64'(rd_busy[1]), 64'h1);
      chk("r3 data", 64'(rd_data[31:0]), 64'h33);

      drive(2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 5'd9);
      drive(2'b01, 5'd9, 32'hCAFE_F00D, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
      chk("same-cycle read r9", 64'(rd_data[31:0]), BYP ? 64'hCAFE_F00D : 64'h99);
      chk("same-cycle busy r9", 64'(rd_busy[0]), BYP ? 64'h0 : 64'h1);
      idle(5'd9, 5'd9);
      chk("next-cycle read r9", 64'(rd_data[31:0]), 64'hCAFE_F00D);
      chk("next-cycle busy r9", 64'(rd_busy[0]), 64'h0);
      drive(2'b01, 5'd10, 32'hA0, 5'd0, 32'h0, 5'd10, 5'd10, 1'b1, 5'd10);
      chk("write+set same r10 busy", 64'(rd_busy[0]), BYP ? 64'h1 : 64'h0);

      for (int k = 1; k <= 8; k++)
         drive(2'(k), 5'(k + 12), 32'(k) * 32'h0101_0101, 5'(k + 20), ~32'(k),
               5'(k + 11), 5'(k + 20), k[0], 5'(k + 19));
      idle(5'd13, 5'd21);
      chk("table r13", 64'(rd_data[31:0]), 64'h0101_0101);

      @(posedge clk);
      #1;
      p_wr_en = 2'b01; p_wr_addr = {6'd0, 6'd63}; p_wr_data = {64'h0, {64{1'b1}}};
      @(posedge clk);
      #1 p_wr_en = 2'b00;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         chk($sformatf("param r63 port%0d", i), p_rd_data[i*64 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the register width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the address bits; depth is 2**ADDR_WIDTH.
REQ-003 The block SHALL have parameter NUM_RD, default 2, range 1..4, meaning the number of read ports.
REQ-004 The block SHALL have parameter NUM_WR, default 2, range 1..2, meaning the number of write ports.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port wr_en, input, NUM_WR bits: per-port write enable.
REQ-008 The block SHALL have port wr_addr, input, NUM_WR*ADDR_WIDTH bits: packed write addresses, port 0 in the LSBs.
REQ-009 The block SHALL have port wr_data, input, NUM_WR*DATA_WIDTH bits: packed write data.
REQ-010 The block SHALL have port rd_addr, input, NUM_RD*ADDR_WIDTH bits: packed read addresses.
REQ-011 The block SHALL have port rd_data, output, NUM_RD*DATA_WIDTH bits: packed read data.
REQ-012 The block SHALL have port rd_busy, output, NUM_RD bits: pending-write flag for each read address.
REQ-013 The block SHALL have port sb_set_en, input, 1 bit: mark one register as pending.
REQ-014 The block SHALL have port sb_set_addr, input, ADDR_WIDTH bits: the register to mark.
REQ-015 The block SHALL have port wr_collide, output, 1 bit: registered pulse indicating a write-port address collision.

Function
REQ-016 Reads SHALL be combinational with zero latency: rd_data[i] = reg[rd_addr[i]].
REQ-017 Address 0 SHALL always read 0 and SHALL never report busy; writes to address 0 SHALL be discarded.
REQ-018 A write with wr_en[j]=1 SHALL update reg[wr_addr[j]] at the next rising clk.
REQ-019 When both write ports target the same nonzero address in one cycle, port 1 SHALL win.
REQ-020 In that collision case, wr_collide SHALL be 1 for exactly the following cycle; otherwise it SHALL be 0.
REQ-021 Scoreboard: a busy bit per register SHALL be set at the clock edge when sb_set_en=1 (for sb_set_addr != 0).
REQ-022 Scoreboard: a busy bit SHALL be cleared at the clock edge by any enabled write to that address.
REQ-023 When a set and a clear target the same address in the same cycle, set SHALL win and the bit SHALL end at 1.
REQ-024 rd_busy[i] SHALL equal busy[rd_addr[i]], subject to REQ-028.
REQ-025 Simultaneous set and clear on different addresses SHALL both take effect.

Reset
REQ-026 While rst_n=0, all registers SHALL be 0 and all busy bits SHALL be 0; this is asynchronous, including mid-write.
REQ-027 While rst_n=0, the outputs SHALL be rd_data=0, rd_busy=0 and wr_collide=0; writes and sets SHALL be ignored until the first clk edge after rst_n rises.

Configuration
REQ-028 With REGFILE_BYPASS_EN defined:
- A read whose nonzero address matches an enabled write in the same cycle SHALL return that wr_data, using the REQ-019 winner.
- That read SHALL report rd_busy=0, unless sb_set_en also targets that address in the same cycle.
REQ-029 Without REGFILE_BYPASS_EN, reads SHALL return the pre-edge array value and the pre-edge busy bit, and no bypass logic SHALL be present.

Structure
REQ-030 A shared package regfile_pkg SHALL hold the default width/depth constants and a function extracting a packed port field.
REQ-031 One sub-module, regfile_scoreboard, SHALL hold the busy vector with its set/clear logic; the data array SHALL remain in regfile_mp.

Verification
REQ-032 Reset: assert rst_n=0 mid-write of 0xDEADBEEF to r5 -> r5 reads 0, rd_busy=0, wr_collide=0.
REQ-033 x0: write 0x1234 to r0 -> rd_data for addr 0 reads 0, and sb_set_en on r0 leaves rd_busy=0.
REQ-034 Collision: port0 writes 0xAAAA_0000 to r7 and port1 writes 0x5555_0000 to r7 in the same cycle -> r7=0x5555_0000 and wr_collide=1 for one cycle.
REQ-035 Scoreboard: set r3, then the next cycle write r3 while setting r3 again -> busy[r3] stays 1; a later plain write -> busy[r3]=0.
REQ-036 Bypass: with the macro, read r9 while writing 0xCAFEF00D to r9 -> same-cycle rd_data=0xCAFEF00D and rd_busy=0; without the macro -> old value, updated value on the next cycle.
REQ-037 Parameters: NUM_RD=4, DATA_WIDTH=64, ADDR_WIDTH=6 -> write r63 with all-ones -> all 4 read ports addressing r63 return 64'hFFFF_FFFF_FFFF_FFFF.
